uart_rx_fifo: RTL and testbench

//  Parametrised UART receiver: configurable data width, optional even/odd parity, oversampled
//  mid-bit sampling with false-start rejection, framing/parity error tagging and an output FIFO

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sfifo.sv | 66 ++++++
 rtl/uart_rx_fifo.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types and constants for the UART receive path.
//   rx_state_t : receiver FSM states
//   RXD_IDLE   : idle (mark) level of the serial line
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam logic RXD_IDLE = 1'b1;

endpackage

// File: rtl/uart_rx_sfifo.sv
// uart_rx_sfifo
//   Synchronous first-word-fall-through FIFO holding received words.
//   Ports:
//     clk, rst_n         clock, async active-low reset
//     push, push_data    write request and word
//     pop                read request; ignored when empty
//     head               current head word (0 when empty)
//     full, empty        occupancy flags
//     count              entries held (0..DEPTH)
//   A push into a full FIFO only succeeds when a pop happens in the same cycle.
`timescale 1ns/1ps
module uart_rx_sfifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = count_q;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage carries no reset; the head output is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Oversampling UART receiver with optional parity, error tagging and an
//   output FIFO with sticky overrun.
//   Ports:
//     clk, rst_n      clock, async active-low reset
//     rxd             asynchronous serial input, idles high
//     sample_tick     1-cycle pulse at OVERSAMPLE x baud
//     read_en         pop FIFO head (ignored when empty)
//     clr_overrun     clears overrun (a new overrun in the same cycle wins)
//     rda             FIFO not empty
//     read_data       head data, 0 when empty
//     rd_frame_err    head: stop bit sampled low
//     rd_parity_err   head: parity mismatch
//     overrun         sticky: a word was dropped because the FIFO was full
//     fifo_count      entries held
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | line high, waiting for a falling edge
//   START     | half a bit time in, confirm start bit is still low
//   DATA      | one sample per bit time, shifted in LSB first
//   PARITY    | sample parity bit and latch mismatch
//   STOP      | sample stop bit and push the word
//   WAIT_HIGH | stop bit was low; wait for line release so a break gives one word
`timescale 1ns/1ps
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rxd,
  input  logic                          sample_tick,
  input  logic                          read_en,
  input  logic                          clr_overrun,
  output logic                          rda,
  output logic [DATA_BITS-1:0]          read_data,
  output logic                          rd_frame_err,
  output logic                          rd_parity_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int   TW     = $clog2(OVERSAMPLE);
  localparam int   BW     = $clog2(DATA_BITS);
  localparam int   WW     = DATA_BITS + 2;
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  localparam rx_state_t AFTER_DATA = (PARITY_EN != 0) ? PARITY : STOP;

  rx_state_t            state;
  logic                 rxd_meta;
  logic                 rxs;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 parity_err;
  logic                 bit_end;
  logic                 push;
  logic [WW-1:0]        push_word;
  logic [WW-1:0]        head;
  logic                 fifo_full;
  logic                 fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= RXD_IDLE;
      rxs      <= RXD_IDLE;
    end else begin
      rxd_meta <= rxd;
      rxs      <= rxd_meta;
    end
  end

  assign bit_end = sample_tick && (tick_cnt == FULL_M1);

  // The push strobe is decoded from the sampling tick itself so the word
  // lands in the FIFO on the same edge the stop bit is sampled.
  assign push      = (state == STOP) && bit_end;
  assign push_word = {parity_err, ~rxs, shift};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rxs != RXD_IDLE) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (sample_tick) begin
            if (tick_cnt == HALF_M1) begin
              tick_cnt <= '0;
              if (rxs == RXD_IDLE) begin
                state <= IDLE;
              end else begin
                state   <= DATA;
                bit_cnt <= '0;
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        DATA: begin
          if (bit_end) begin
            tick_cnt <= '0;
            shift    <= {rxs, shift[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
              state      <= AFTER_DATA;
              parity_err <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else if (sample_tick) begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        PARITY: begin
          if (bit_end) begin
            tick_cnt   <= '0;
            parity_err <= ((^shift) ^ rxs) != PAR_ODD;
            state      <= STOP;
          end else if (sample_tick) begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            tick_cnt <= '0;
            state    <= (rxs == RXD_IDLE) ? IDLE : WAIT_HIGH;
          end else if (sample_tick) begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        WAIT_HIGH: begin
          if (rxs == RXD_IDLE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_rx_sfifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_word),
    .pop       (read_en),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A simultaneous pop makes room, so only an unaccompanied push into a
  // full FIFO counts as a drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (push && fifo_full && !read_en) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

  assign rda           = ~fifo_empty;
  assign read_data     = head[DATA_BITS-1:0];
  assign rd_frame_err  = head[DATA_BITS];
  assign rd_parity_err = head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int DEPTH  = 4;
  localparam int BIT_NS = 640;   // 16 ticks x 4 clks x 10 ns

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_tick = 1'b0;
  logic       rxd, rxd_p;
  logic       read_en = 1'b0, read_en_p = 1'b0;
  logic       clr_overrun, clr_p;
  logic       rda, rda_p;
  logic [7:0] read_data, read_data_p;
  logic       rd_frame_err, rd_frame_err_p;
  logic       rd_parity_err, rd_parity_err_p;
  logic       overrun, overrun_p;
  logic [2:0] fifo_count, fifo_count_p;

  int  n_pass = 0;
  int  n_tot  = 0;
  bit  auto_read = 1'b0;
  bit  pop_now   = 1'b0;
  bit  exp_ovr   = 1'b0;
  logic [9:0] sb[$];
  logic [9:0] sb_p[$];

  uart_rx_fifo dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .sample_tick(sample_tick),
    .read_en(read_en), .clr_overrun(clr_overrun), .rda(rda),
    .read_data(read_data), .rd_frame_err(rd_frame_err),
    .rd_parity_err(rd_parity_err), .overrun(overrun), .fifo_count(fifo_count)
  );

  uart_rx_fifo #(.PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_p), .sample_tick(sample_tick),
    .read_en(read_en_p), .clr_overrun(clr_p), .rda(rda_p),
    .read_data(read_data_p), .rd_frame_err(rd_frame_err_p),
    .rd_parity_err(rd_parity_err_p), .overrun(overrun_p), .fifo_count(fifo_count_p)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    repeat (3) @(posedge clk);
    #1 sample_tick = 1'b1;
    @(posedge clk);
    #1 sample_tick = 1'b0;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: sim time exceeded, got %0d/%0d", n_pass, n_tot);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitors: whenever a word is popped, compare the head with the oldest expectation.
  always @(negedge clk) begin
    if (rda && (auto_read || pop_now)) begin
      if (sb.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_word: got 0x%0h expected none",
                 {rd_parity_err, rd_frame_err, read_data});
      end else begin
        chk("pop_8n1", {rd_parity_err, rd_frame_err, read_data}, sb.pop_front());
      end
      read_en = 1'b1;
    end else begin
      read_en = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rda_p) begin
      if (sb_p.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_word_par: got 0x%0h expected none",
                 {rd_parity_err_p, rd_frame_err_p, read_data_p});
      end else begin
        chk("pop_8e1", {rd_parity_err_p, rd_frame_err_p, read_data_p}, sb_p.pop_front());
      end
      read_en_p = 1'b1;
    end else begin
      read_en_p = 1'b0;
    end
  end

  task automatic drive_rx(input bit which, input logic v);
    if (which) rxd_p = v;
    else       rxd   = v;
  endtask

  // mode: 0 = model decides accept/drop, 1 = a pop coincides with the push, 2 = untracked
  task automatic send_frame(input bit which, input logic [7:0] data, input bit pbit,
                            input bit stop, input int mode);
    int   ones;
    logic perr;
    ones = $countones(data) + int'(pbit);
    perr = which && (ones % 2 == 1);
    if (which) sb_p.push_back({perr, ~stop, data});
    else if (mode == 1 || (mode == 0 && sb.size() < DEPTH)) sb.push_back({1'b0, ~stop, data});
    else if (mode == 0) exp_ovr = 1'b1;
    drive_rx(which, 1'b0);
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      drive_rx(which, data[i]);
      #(BIT_NS);
    end
    if (which) begin
      drive_rx(which, pbit);
      #(BIT_NS);
    end
    drive_rx(which, stop);
    #(BIT_NS);
    drive_rx(which, 1'b1);
    #(2 * BIT_NS);
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (!sample_tick);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000 && (sb.size() != 0 || sb_p.size() != 0); i++) @(posedge clk);
    chk(name, sb.size() + sb_p.size(), 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rda"},       rda, 0);
    chk({tag, "_data"},      read_data, 0);
    chk({tag, "_errs"},      {rd_parity_err, rd_frame_err}, 0);
    chk({tag, "_overrun"},   overrun, 0);
    chk({tag, "_count"},     fifo_count, 0);
  endtask

  initial begin
    rst_n = 1'b0; rxd = 1'b1; rxd_p = 1'b1; clr_overrun = 1'b0; clr_p = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_idle("reset");
    chk("reset_par_rda", rda_p, 0);
    @(negedge clk) rst_n = 1'b1;

    // T1: single 8N1 frame, held until read
    send_frame(0, 8'hA5, 0, 1, 0);
    chk("t1_rda", rda, 1);
    chk("t1_count", fifo_count, 1);
    auto_read = 1'b1;
    drain("t1_drain");
    @(negedge clk);
    chk("t1_rda_after", rda, 0);
    chk("t1_count_after", fifo_count, 0);

    // random 8N1 with occasional framing errors
    for (int i = 0; i < 8; i++)
      send_frame(0, 8'($urandom), 0, $urandom_range(0, 3) != 0, 0);
    drain("rand_8n1_drain");

    // T2 even parity, then random parity frames
    send_frame(1, 8'h5A, 0, 1, 0);
    send_frame(1, 8'h5A, 1, 1, 0);
    for (int i = 0; i < 8; i++)
      send_frame(1, 8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, 0);
    drain("rand_8e1_drain");

    // T3: short glitch is rejected, next frame is clean
    rxd = 1'b0;
    #(240);
    rxd = 1'b1;
    #(2 * BIT_NS);
    chk("t3_rda", rda, 0);
    chk("t3_count", fifo_count, 0);
    send_frame(0, 8'h3C, 0, 1, 0);
    drain("t3_drain");

    // T4: break held for three frame times gives exactly one word
    sb.push_back({1'b0, 1'b1, 8'h00});
    rxd = 1'b0;
    #(30 * BIT_NS);
    rxd = 1'b1;
    #(2 * BIT_NS);
    drain("t4_break_drain");
    chk("t4_count", fifo_count, 0);
    send_frame(0, 8'h11, 0, 1, 0);
    drain("t4_drain");

    // T5: overrun on fifth word, reads return first four, clear
    auto_read = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 0, 1, 0);
    chk("t5_count", fifo_count, 4);
    chk("t5_overrun", overrun, exp_ovr);
    auto_read = 1'b1;
    drain("t5_drain");
    @(negedge clk);
    chk("t5_overrun_sticky", overrun, 1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    exp_ovr = 1'b0;
    chk("t5_overrun_clr", overrun, exp_ovr);

    // T6: full FIFO, pop in the push cycle
    auto_read = 1'b0;
    for (int i = 0; i < 4; i++) send_frame(0, 8'h10 + 8'(i), 0, 1, 0);
    chk("t6_count_full", fifo_count, 4);
    do @(posedge clk); while (!sample_tick);
    #2;
    fork
      send_frame(0, 8'h14, 0, 1, 1);
      begin
        // 8 start + 8x16 data + 16 stop ticks: push on tick 152
        wait_ticks(151);
        repeat (3) @(posedge clk);
        pop_now = 1'b1;
        @(posedge clk);
        pop_now = 1'b0;
      end
    join
    chk("t6_count", fifo_count, 4);
    chk("t6_overrun", overrun, 0);
    chk("t6_sb_level", sb.size(), 4);

    // reset in the middle of the data bits
    fork
      send_frame(0, 8'h96, 0, 1, 2);
      begin
        #(3 * BIT_NS + 100);
        rst_n = 1'b0;
        #1 chk_idle("mid_reset");
        sb.delete();
        exp_ovr = 1'b0;
      end
    join
    @(negedge clk) rst_n = 1'b1;
    auto_read = 1'b1;
    send_frame(0, 8'h42, 0, 1, 0);
    drain("t6_recover_drain");
    chk("final_overrun", overrun, exp_ovr);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
